// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: opcodes, FSM states and instruction field offsets.
// Opcode 5 is JNZ when ALU_SEQ_JNZ_EN is defined, SHL otherwise.
package alu_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
`ifdef ALU_SEQ_JNZ_EN
    OP_JNZ  = 3'd5,
`else
    OP_SHL  = 3'd5,
`endif
    OP_LDI  = 3'd6,
    OP_HALT = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Instruction layout, MSB to LSB: op | rd | rs | imm
  function automatic int instr_w(input int data_w, input int rsel_w);
    return OP_W + 2 * rsel_w + data_w;
  endfunction

  function automatic int op_lsb(input int data_w, input int rsel_w);
    return data_w + 2 * rsel_w;
  endfunction

  function automatic int rd_lsb(input int data_w, input int rsel_w);
    return data_w + rsel_w;
  endfunction

  function automatic int rs_lsb(input int data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, next carry and register write-enable for one opcode.
// With ALU_SEQ_JNZ_EN defined, opcode 5 (JNZ) writes nothing here; the sequencer handles the jump.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              carry_in,
  output logic [DATA_W-1:0] y,
  output logic              carry,
  output logic              we
);

  opcode_e         op_e;
  logic [DATA_W:0] sum;

  assign op_e = opcode_e'(op);

  always_comb begin
    y     = a;
    carry = carry_in;
    we    = 1'b1;
    sum   = '0;
    case (op_e)
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        y     = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      OP_SUB: begin
        y     = a - b;
        carry = (b > a);
      end
      OP_AND: begin
        y     = a & b;
        carry = 1'b0;
      end
      OP_OR: begin
        y     = a | b;
        carry = 1'b0;
      end
      OP_XOR: begin
        y     = a ^ b;
        carry = 1'b0;
      end
`ifdef ALU_SEQ_JNZ_EN
      OP_JNZ: we = 1'b0;
`else
      OP_SHL: begin
        y     = {a[DATA_W-2:0], 1'b0};
        carry = a[DATA_W-1];
      end
`endif
      OP_LDI:  y  = b;   // carry passes through unchanged
      OP_HALT: we = 1'b0;
      default: we = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Self-sequencing execution unit: host-loaded program memory, pc, register file, carry flag.
// Define ALU_SEQ_JNZ_EN to turn opcode 5 into a conditional jump instead of SHL.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int RSEL_W = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               prog_we,
  input  logic [ADDR_W-1:0]                  prog_addr,
  input  logic [instr_w(DATA_W, RSEL_W)-1:0] prog_data,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic [ADDR_W-1:0]                  pc,
  output logic [DATA_W-1:0]                  result_out,
  output logic                               carry_out,
  input  logic [RSEL_W-1:0]                  dbg_sel,
  output logic [DATA_W-1:0]                  dbg_data
);

  localparam int INSTR_W = instr_w(DATA_W, RSEL_W);
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int NREGS   = 1 << RSEL_W;
  localparam int OP_LSB  = op_lsb(DATA_W, RSEL_W);
  localparam int RD_LSB  = rd_lsb(DATA_W, RSEL_W);
  localparam int RS_LSB  = rs_lsb(DATA_W);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [INSTR_W-1:0] ir_q;
  logic [DATA_W-1:0]  regs [NREGS];

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   result_q, result_d;

  logic                mem_we;
  logic                fetch_en;
  logic                rf_we;
  logic [2:0]          ir_op;
  opcode_e             ir_opcode;
  logic [RSEL_W-1:0]   ir_rd;
  logic [RSEL_W-1:0]   ir_rs;
  logic [DATA_W-1:0]   ir_imm;
  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W-1:0]   rs_val;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_y;
  logic                alu_carry;
  logic                alu_we;

  assign ir_op     = ir_q[OP_LSB +: OP_W];
  assign ir_opcode = opcode_e'(ir_op);
  assign ir_rd     = ir_q[RD_LSB +: RSEL_W];
  assign ir_rs     = ir_q[RS_LSB +: RSEL_W];
  assign ir_imm    = ir_q[DATA_W-1:0];
  assign rd_val    = regs[ir_rd];
  assign rs_val    = regs[ir_rs];
  assign alu_b     = (ir_opcode == OP_LDI) ? ir_imm : rs_val;

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op       (ir_op),
    .a        (rd_val),
    .b        (alu_b),
    .carry_in (carry_q),
    .y        (alu_y),
    .carry    (alu_carry),
    .we       (alu_we)
  );

  // Host writes only land while the program is not running.
  assign mem_we   = prog_we && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign fetch_en = (state_q == ST_FETCH);

  // Program memory has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[prog_addr] <= prog_data;
    end
    if (fetch_en) begin
      ir_q <= mem[pc_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    carry_d  = carry_q;
    result_d = result_q;
    rf_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          busy_d  = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        if (ir_opcode == OP_HALT) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FETCH;
          pc_d    = pc_q + ADDR_W'(1);
          carry_d = alu_carry;
          if (alu_we) begin
            rf_we    = 1'b1;
            result_d = alu_y;
          end
`ifdef ALU_SEQ_JNZ_EN
          if ((ir_opcode == OP_JNZ) && (rd_val != '0)) begin
            pc_d = ADDR_W'(ir_imm);
          end
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
    logic [DATA_W-1:0] rf_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        rf_q <= '0;
      end else if (rf_we && (ir_rd == RSEL_W'(gi))) begin
        rf_q <= alu_y;
      end
    end
    assign regs[gi] = rf_q;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pc         = pc_q;
  assign result_out = result_q;
  assign carry_out  = carry_q;
  assign dbg_data   = regs[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: an instruction-level interpreter predicts every
// cycle's outputs from the 2-cycles-per-instruction timing rules; directed plus random programs.
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int RW    = 2;
  localparam int IW    = 3 + 2 * RW + DW;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] pc;
  logic [DW-1:0] result_out;
  logic          carry_out;
  logic [RW-1:0] dbg_sel = '0;
  logic [DW-1:0] dbg_data;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(DW), .ADDR_W(AW), .RSEL_W(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pc         (pc),
    .result_out (result_out),
    .carry_out  (carry_out),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  typedef struct packed {
    logic                busy;
    logic                done;
    logic [AW-1:0]       pc;
    logic [DW-1:0]       res;
    logic                carry;
    logic [3:0][DW-1:0]  regs;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] prog_q[$];
  int            checks = 0;
  int            failures = 0;
  bit            cmp_on = 1'b0;
  int            cmp_cyc = 0;

  // Architectural state of the reference interpreter
  logic [IW-1:0] m_prog [DEPTH];
  int            m_regs [4];
  int            m_pc, m_carry, m_res;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs, input int imm);
    return {op[2:0], rd[1:0], rs[1:0], imm[7:0]};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_pc = 0; m_carry = 0; m_res = 0;
  endfunction

  function automatic void push(input bit b, input bit d);
    exp_t e;
    e.busy  = b;
    e.done  = d;
    e.pc    = AW'(m_pc);
    e.res   = DW'(m_res);
    e.carry = m_carry[0];
    for (int i = 0; i < 4; i++) e.regs[i] = DW'(m_regs[i]);
    exp_q.push_back(e);
  endfunction

  // Instruction k is visible as two cycles (fetch, exec) showing pre-execution state;
  // a HALT adds the done cycle and one trailing idle cycle.
  task automatic model_run(input int maxc, output int done_cyc, output int busy_cyc);
    int c, op, rd, rs, imm, a, b;
    bit halted, jumped;
    logic [IW-1:0] w;
    c = 0; halted = 0; done_cyc = 0; m_pc = 0;
    while (!halted && c < maxc) begin
      w   = m_prog[m_pc];
      op  = int'(w[14:12]);
      rd  = int'(w[11:10]);
      rs  = int'(w[9:8]);
      imm = int'(w[7:0]);
      for (int k = 0; k < 2; k++) if (c < maxc) begin push(1'b1, 1'b0); c++; end
      a = m_regs[rd];
      b = m_regs[rs];
      jumped = 0;
      if (op == 7) halted = 1;
      else begin
        case (op)
          0: begin m_carry = (a + b > 255) ? 1 : 0; m_regs[rd] = (a + b) % 256; end
          1: begin m_carry = (b > a) ? 1 : 0; m_regs[rd] = (a - b + 256) % 256; end
          2: begin m_carry = 0; m_regs[rd] = a & b; end
          3: begin m_carry = 0; m_regs[rd] = a | b; end
          4: begin m_carry = 0; m_regs[rd] = a ^ b; end
`ifdef ALU_SEQ_JNZ_EN
          5: if (a != 0) begin m_pc = imm % DEPTH; jumped = 1; end
`else
          5: begin m_carry = (a >= 128) ? 1 : 0; m_regs[rd] = (a * 2) % 256; end
`endif
          default: m_regs[rd] = imm;
        endcase
`ifdef ALU_SEQ_JNZ_EN
        if (op != 5) m_res = m_regs[rd];
`else
        m_res = m_regs[rd];
`endif
        if (!jumped) m_pc = (m_pc + 1) % DEPTH;
      end
    end
    busy_cyc = c;
    if (halted) begin
      push(1'b0, 1'b1);
      done_cyc = c + 1;
      push(1'b0, 1'b0);
    end
  endtask

  always @(negedge clk) begin : cmp_proc
    exp_t e;
    if (cmp_on && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp_cyc++;
      check($sformatf("busy@c%0d", cmp_cyc), busy, e.busy);
      check($sformatf("done@c%0d", cmp_cyc), done, e.done);
      check($sformatf("pc@c%0d", cmp_cyc), pc, e.pc);
      check($sformatf("result@c%0d", cmp_cyc), result_out, e.res);
      check($sformatf("carry@c%0d", cmp_cyc), carry_out, e.carry);
      dbg_sel = RW'($urandom_range(0, 3));
      #1;
      check($sformatf("dbg_r%0d@c%0d", dbg_sel, cmp_cyc), dbg_data, e.regs[dbg_sel]);
    end
  end

  task automatic load_prog();
    foreach (prog_q[i]) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = AW'(i);
      prog_data = prog_q[i];
      m_prog[i] = prog_q[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int maxc, input bit noise, output int done_cyc);
    int busy_cyc, budget, cyc;
    model_run(maxc, done_cyc, busy_cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cmp_cyc = 0;
    cmp_on  = 1'b1;
    budget  = exp_q.size() + 20;
    cyc     = 0;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      #2;
      cyc++;
      budget--;
      if (noise && cyc <= busy_cyc) begin
        prog_we   = ($urandom_range(0, 1) == 1);
        prog_addr = AW'($urandom);
        prog_data = IW'($urandom);
        start     = ($urandom_range(0, 3) == 0);
      end else begin
        prog_we = 1'b0;
        start   = 1'b0;
      end
    end
    prog_we = 1'b0;
    start   = 1'b0;
    cmp_on  = 1'b0;
    check({"drain_", tag}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    $display("run %s: done_cycle=%0d result=%0h carry=%0d pc=%0d", tag, done_cyc, result_out, carry_out, pc);
  endtask

  // rst is raised now, so it is sampled at the next edge; the following cycle must be all zeros.
  task automatic reset_and_check(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_result"}, result_out, 0);
    check({tag, "_carry"}, carry_out, 0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = RW'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), dbg_data, 0);
    end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic peek_reg(input string name, input int sel, input int req);
    dbg_sel = RW'(sel);
    #1;
    check(name, dbg_data, 64'(req));
  endtask

  initial begin
    int dc, len, op;
    model_clear();
    for (int i = 0; i < DEPTH; i++) m_prog[i] = '0;
    reset_and_check("init");

    // Clear the whole memory so every address holds a known word
    prog_q = {};
    for (int i = 0; i < DEPTH; i++) prog_q.push_back(enc(7, 0, 0, 0));
    load_prog();

    prog_q = {};
    prog_q.push_back(enc(6, 0, 0, 5));
    prog_q.push_back(enc(6, 1, 0, 3));
    prog_q.push_back(enc(0, 0, 1, 0));
    prog_q.push_back(enc(7, 0, 0, 0));
    load_prog();
    run_prog("add", 1000, 1'b0, dc);
    check("add_done_cycle", 64'(dc), 64'd9);
    check("add_result", result_out, 8'd8);
    check("add_carry", carry_out, 0);
    peek_reg("add_r0", 0, 8);

    prog_q = {};
    prog_q.push_back(enc(6, 0, 0, 8'hFF));
    prog_q.push_back(enc(6, 1, 0, 8'h01));
    prog_q.push_back(enc(0, 0, 1, 0));
    prog_q.push_back(enc(7, 0, 0, 0));
    load_prog();
    run_prog("add_ovf", 1000, 1'b0, dc);
    check("ovf_result", result_out, 8'h00);
    check("ovf_carry", carry_out, 1);

    prog_q = {};
    prog_q.push_back(enc(1, 1, 0, 0));
    prog_q.push_back(enc(7, 0, 0, 0));
    load_prog();
    run_prog("sub_keep", 1000, 1'b0, dc);
    check("subk_result", result_out, 8'h01);
    check("subk_carry", carry_out, 0);

    prog_q = {};
    prog_q.push_back(enc(6, 0, 0, 3));
    prog_q.push_back(enc(6, 1, 0, 5));
    prog_q.push_back(enc(1, 0, 1, 0));
    prog_q.push_back(enc(7, 0, 0, 0));
    load_prog();
    run_prog("sub_borrow", 1000, 1'b0, dc);
    check("subb_result", result_out, 8'hFE);
    check("subb_carry", carry_out, 1);

`ifdef ALU_SEQ_JNZ_EN
    prog_q = {};
    prog_q.push_back(enc(6, 0, 0, 3));
    prog_q.push_back(enc(6, 1, 0, 1));
    prog_q.push_back(enc(1, 0, 1, 0));
    prog_q.push_back(enc(5, 0, 0, 2));
    prog_q.push_back(enc(7, 0, 0, 0));
    load_prog();
    run_prog("jnz", 1000, 1'b0, dc);
    check("jnz_pc", pc, 4);
    peek_reg("jnz_r0", 0, 0);
`else
    prog_q = {};
    prog_q.push_back(enc(6, 2, 0, 8'h81));
    prog_q.push_back(enc(5, 2, 0, 0));
    prog_q.push_back(enc(7, 0, 0, 0));
    load_prog();
    run_prog("shl", 1000, 1'b0, dc);
    check("shl_result", result_out, 8'h02);
    check("shl_carry", carry_out, 1);
`endif

    // 16 words without HALT: pc wraps, busy stays high, host writes during the run are dropped
    prog_q = {};
    for (int i = 0; i < DEPTH; i++) prog_q.push_back(enc(6, i % 4, 0, 16 + i));
    load_prog();
    run_prog("nohalt", 48, 1'b1, dc);
    check("nohalt_no_done", 64'(dc), 64'd0);
    reset_and_check("nohalt_rst");
    run_prog("nohalt_again", 48, 1'b0, dc);
    reset_and_check("nohalt_rst2");

    // Reset in cycle 5 of a run, then re-run the retained program
    prog_q = {};
    prog_q.push_back(enc(6, 0, 0, 5));
    prog_q.push_back(enc(6, 1, 0, 3));
    prog_q.push_back(enc(0, 0, 1, 0));
    prog_q.push_back(enc(7, 0, 0, 0));
    load_prog();
    run_prog("midrun", 5, 1'b0, dc);
    reset_and_check("midrun_rst");
    run_prog("rerun", 1000, 1'b0, dc);
    check("rerun_result", result_out, 8'd8);

    for (int t = 0; t < 15; t++) begin
      len = $urandom_range(2, 9);
      prog_q = {};
      for (int i = 0; i < len; i++) begin
        op = $urandom_range(0, 6);
`ifdef ALU_SEQ_JNZ_EN
        if (op == 5) op = 6;
`endif
        prog_q.push_back(enc(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255)));
      end
      prog_q.push_back(enc(7, 0, 0, 0));
      load_prog();
      run_prog($sformatf("rand%0d", t), 1000, 1'b1, dc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
